// File: rtl/regunit_pkg.sv
// Shared constants and types for the integer register unit.
package regunit_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NREGS    = 1 << AW;
  localparam int ZERO_REG = 0;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [AW-1:0]   ridx_t;
  typedef logic [AW:0]     cnt_t;

endpackage

// File: rtl/register_bank_if.sv
// Bus bundle between the pipeline (master) and register_bank (slave):
// write-back, issue, hazard-check sources and the parallel read-out.
interface register_bank_if;
  import regunit_pkg::*;

  logic                    wb_we;
  ridx_t                   wb_rd;
  xlen_t                   wb_data;
  logic                    iss_valid;
  ridx_t                   iss_rd;
  ridx_t                   rs1;
  ridx_t                   rs2;
  logic [NREGS*XLEN-1:0]   regs_q;
  logic [NREGS-1:0]        busy_q;
  logic                    hazard;
  cnt_t                    pend_cnt;

  modport master (
    output wb_we, wb_rd, wb_data, iss_valid, iss_rd, rs1, rs2,
    input  regs_q, busy_q, hazard, pend_cnt
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, iss_valid, iss_rd, rs1, rs2,
    output regs_q, busy_q, hazard, pend_cnt
  );

endinterface

// File: rtl/regbank_scoreboard.sv
// Pending-write scoreboard: busy vector, pending count and RAW hazard detect.
// REGBANK_WRITE_BYPASS_EN masks sources that are being written back this cycle.
module regbank_scoreboard
  import regunit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid_i,
  input  ridx_t            iss_rd_i,
  input  logic             wb_we_i,
  input  ridx_t            wb_rd_i,
  input  ridx_t            rs1_i,
  input  ridx_t            rs2_i,
  output logic [NREGS-1:0] busy_o,
  output cnt_t             pend_cnt_o,
  output logic             hazard_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  cnt_t             pend_cnt_q, pend_cnt_d;
  logic             set_v, inc, dec;
  logic             byp1, byp2;

  always_comb begin
    set_v  = iss_valid_i && (iss_rd_i != ridx_t'(ZERO_REG));
    busy_d = busy_q;
    if (wb_we_i) busy_d[wb_rd_i] = 1'b0;
    // A new writer supersedes the one retiring, so set is applied last.
    if (set_v)   busy_d[iss_rd_i] = 1'b1;
    inc = set_v && !busy_q[iss_rd_i];
    dec = wb_we_i && busy_q[wb_rd_i] && !(set_v && (iss_rd_i == wb_rd_i));
    pend_cnt_d = pend_cnt_q + cnt_t'(inc) - cnt_t'(dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

`ifdef REGBANK_WRITE_BYPASS_EN
  assign byp1 = wb_we_i && (wb_rd_i == rs1_i);
  assign byp2 = wb_we_i && (wb_rd_i == rs2_i);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign hazard_o   = (busy_q[rs1_i] & ~byp1) | (busy_q[rs2_i] & ~byp2);
  assign busy_o     = busy_q;
  assign pend_cnt_o = pend_cnt_q;

endmodule

// File: rtl/register_bank.sv
// Architectural register storage x0..x31 with parallel read-out and scoreboard.
// REGBANK_WRITE_BYPASS_EN makes the write-back value visible in its own cycle.
module register_bank
  import regunit_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  register_bank_if.slave bus
);

  xlen_t                 mem_q [NREGS];
  logic                  wr_en;
  logic [NREGS*XLEN-1:0] regs_flat;

  assign wr_en = bus.wb_we && (bus.wb_rd != ridx_t'(ZERO_REG));

  // mem_q[0] is only ever reset, so it stays a constant zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 1; i < NREGS; i++) begin
      regs_flat[i*XLEN +: XLEN] = mem_q[i];
`ifdef REGBANK_WRITE_BYPASS_EN
      if (wr_en && (bus.wb_rd == ridx_t'(i))) regs_flat[i*XLEN +: XLEN] = bus.wb_data;
`endif
    end
  end

  assign bus.regs_q = regs_flat;

  regbank_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid_i (bus.iss_valid),
    .iss_rd_i    (bus.iss_rd),
    .wb_we_i     (bus.wb_we),
    .wb_rd_i     (bus.wb_rd),
    .rs1_i       (bus.rs1),
    .rs2_i       (bus.rs2),
    .busy_o      (bus.busy_q),
    .pend_cnt_o  (bus.pend_cnt),
    .hazard_o    (bus.hazard)
  );

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank; expectations queued per cycle, checked at negedge.
module tb_register_bank;
  import regunit_pkg::*;

  localparam int K_REG = 0, K_BUSY = 1, K_PEND = 2, K_HAZ = 3;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  chk_t sbq[$];

  register_bank_if bus();

  register_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] sample(int kind, int idx);
    case (kind)
      K_REG:   return bus.regs_q[idx*XLEN +: XLEN];
      K_BUSY:  return bus.busy_q;
      K_PEND:  return 32'(bus.pend_cnt);
      default: return 32'(bus.hazard);
    endcase
  endfunction

  task automatic compare(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_v(string nm, int kind, int idx, logic [31:0] exp);
    chk_t e;
    e.cyc = cyc; e.kind = kind; e.idx = idx; e.exp = exp; e.name = nm;
    sbq.push_back(e);
  endtask

  // Monitor: at each negedge, check every expectation queued for this cycle.
  initial forever begin
    @(negedge clk);
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      chk_t e;
      e = sbq.pop_front();
      compare(e.name, sample(e.kind, e.idx), e.exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_we = 1'b0; bus.iss_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    expect_v("rst_reg5", K_REG, 5, 32'h0);
    expect_v("rst_busy", K_BUSY, 0, 32'h0);
    expect_v("rst_pend", K_PEND, 0, 32'h0);
    expect_v("rst_haz",  K_HAZ,  0, 32'h0);

    // basic write
    bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h1234_5678;
    step(); idle();
    expect_v("wr_reg7", K_REG, 7, 32'h1234_5678);
    expect_v("wr_reg6", K_REG, 6, 32'h0);
    expect_v("wr_reg8", K_REG, 8, 32'h0);

    // x0 protection
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    expect_v("x0_reg0_wrcyc", K_REG, 0, 32'h0);
    step(); idle();
    expect_v("x0_reg0",  K_REG,  0, 32'h0);
    expect_v("x0_busy",  K_BUSY, 0, 32'h0);
    expect_v("x0_pend",  K_PEND, 0, 32'h0);
    expect_v("x0_haz",   K_HAZ,  0, 32'h0);

    // hazard on rs1 = 3
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    step(); idle();
    bus.rs1 = 5'd3;
    expect_v("haz_set",  K_HAZ,  0, 32'h1);
    expect_v("haz_pend", K_PEND, 0, 32'h1);
    expect_v("haz_busy", K_BUSY, 0, 32'h0000_0008);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hA5A5_0003;
`ifdef REGBANK_WRITE_BYPASS_EN
    expect_v("haz_wbcyc",     K_HAZ, 0, 32'h0);
    expect_v("reg3_wbcyc",    K_REG, 3, 32'hA5A5_0003);
`else
    expect_v("haz_wbcyc",     K_HAZ, 0, 32'h1);
    expect_v("reg3_wbcyc",    K_REG, 3, 32'h0);
`endif
    step(); idle();
    expect_v("haz_after", K_HAZ,  0, 32'h0);
    expect_v("reg3",      K_REG,  3, 32'hA5A5_0003);
    expect_v("pend_after",K_PEND, 0, 32'h0);

    // hazard on rs2
    bus.rs1 = 5'd0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
    step(); idle();
    bus.rs2 = 5'd12;
    expect_v("haz_rs2", K_HAZ, 0, 32'h1);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd12; bus.wb_data = 32'h0000_0C0C;
    step(); idle();
    bus.rs2 = 5'd0;
    expect_v("rs2_clr_pend", K_PEND, 0, 32'h0);

    // simultaneous set and clear on x9
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step();
    bus.wb_we = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h0000_0099;
    expect_v("sc_pend_pre", K_PEND, 0, 32'h1);
    step(); idle();
    expect_v("sc_busy", K_BUSY, 0, 32'h0000_0200);
    expect_v("sc_pend", K_PEND, 0, 32'h1);
    expect_v("sc_reg9", K_REG,  9, 32'h0000_0099);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h0000_0999;
    step(); idle();
    expect_v("sc_busy_clr", K_BUSY, 0, 32'h0);
    expect_v("sc_pend_clr", K_PEND, 0, 32'h0);

    // clear while not busy
    bus.wb_we = 1'b1; bus.wb_rd = 5'd20; bus.wb_data = 32'h2020_2020;
    step(); idle();
    expect_v("nb_pend",  K_PEND, 0, 32'h0);
    expect_v("nb_busy",  K_BUSY, 0, 32'h0);
    expect_v("nb_reg20", K_REG, 20, 32'h2020_2020);

    // fill the scoreboard
    for (int i = 1; i < 32; i++) begin
      bus.iss_valid = 1'b1; bus.iss_rd = ridx_t'(i);
      if (i == 16) expect_v("fill_pend15", K_PEND, 0, 32'd15);
      step();
    end
    idle();
    bus.rs1 = 5'd17;
    expect_v("fill_pend",  K_PEND, 0, 32'd31);
    expect_v("fill_busy",  K_BUSY, 0, 32'hFFFF_FFFE);
    expect_v("fill_haz",   K_HAZ,  0, 32'h1);
    step();
    bus.rs1 = 5'd0;
    for (int i = 1; i < 32; i++) begin
      bus.wb_we = 1'b1; bus.wb_rd = ridx_t'(i); bus.wb_data = 32'h0101_0101 * i;
      step();
    end
    idle();
    expect_v("drain_pend",  K_PEND, 0, 32'd0);
    expect_v("drain_busy",  K_BUSY, 0, 32'h0);
    expect_v("drain_reg1",  K_REG,  1, 32'h0101_0101);
    expect_v("drain_reg31", K_REG, 31, 32'h1F1F_1F1F);
    expect_v("drain_reg0",  K_REG,  0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1 = ridx_t'(i); bus.rs2 = ridx_t'(31 - i);
      expect_v("sweep_haz", K_HAZ, 0, 32'h0);
      step();
    end

    // asynchronous reset mid-operation
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd6;
    step(); idle();
    bus.rs1 = 5'd6; bus.rs2 = 5'd0;
    expect_v("pre_rst_reg5", K_REG,  5, 32'hDEAD_BEEF);
    expect_v("pre_rst_pend", K_PEND, 0, 32'h1);
    expect_v("pre_rst_haz",  K_HAZ,  0, 32'h1);
    #6;
    rst_n = 1'b0;
    #1;
    compare("arst_reg5", sample(K_REG, 5), 32'h0);
    compare("arst_reg7", sample(K_REG, 7), 32'h0);
    compare("arst_busy", sample(K_BUSY, 0), 32'h0);
    compare("arst_pend", sample(K_PEND, 0), 32'h0);
    compare("arst_haz",  sample(K_HAZ, 0), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    expect_v("post_rst_busy", K_BUSY, 0, 32'h0);
    expect_v("post_rst_reg5", K_REG,  5, 32'h0);
    step();
    @(negedge clk);
    #1;
    compare("queue_drained", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Architectural integer register storage (x0..x31) for the pipelined core.
- Sits directly upstream of the 32:1 read-select multiplexers in the register unit. It drives every register value in parallel on a packed bus; each read multiplexer picks one value from that bus.
- Holds a write-back port and a per-register pending-write scoreboard. The decode stage uses the scoreboard to detect read-after-write hazards and stall.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (power of two)
- AW, 5, register index width, equal to log2(NREGS)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wb_we  in  1  write-back enable
- wb_rd  in  AW  write-back destination index
- wb_data  in  XLEN  write-back data
- iss_valid  in  1  decode issues an instruction that will write a register
- iss_rd  in  AW  destination index of the issued instruction
- rs1  in  AW  source index 1 for the hazard check
- rs2  in  AW  source index 2 for the hazard check
- regs_q  out  NREGS*XLEN  packed register values; register i occupies bits [i*XLEN +: XLEN]
- busy_q  out  NREGS  pending-write flag per register
- hazard  out  1  combinational: busy_q[rs1] OR busy_q[rs2]
- pend_cnt  out  AW+1  number of set bits in busy_q

Behaviour:
- Reset is asynchronous, active-low, and applies immediately on rst_n low: all registers = 0, busy_q = 0, pend_cnt = 0. hazard then reads 0.
- Reset asserted mid-operation discards all pending writes and scoreboard state, with no partial update.
- Write:
  - On a rising edge with wb_we=1 and wb_rd!=0, reg[wb_rd] <= wb_data.
  - Latency is 1 cycle: the new value appears on regs_q after that edge.
- x0:
  - Writes to index 0 are ignored, so regs_q[0 +: XLEN] is always 0.
  - busy_q[0] is never set, so hazard never fires on x0.
- Scoreboard, evaluated per register r each edge:
  - set when iss_valid=1 and iss_rd=r and r!=0;
  - clear when wb_we=1 and wb_rd=r;
  - set and clear on the same r in the same cycle: set wins and busy stays 1, because the new writer supersedes the old one;
  - clear while not busy: no effect and no error;
  - set while already busy (two writers in flight): stays 1; the first write-back clears it. The pipeline guarantees in-order write-back.
- pend_cnt:
  - Registered, updated every cycle by +1, -1 or 0 so that it always equals popcount(busy_q) after the edge.
  - It has no wrap; its maximum is NREGS-1.
- hazard:
  - Purely combinational from busy_q, rs1 and rs2, and does not look at wb_we in the same cycle.
  - The hazard therefore clears one cycle after the write-back edge, unless the optional bypass is enabled.

Optional Feature:
- Macro: REGBANK_WRITE_BYPASS_EN.
- Defined:
  - regs_q[wb_rd] shows wb_data combinationally in the write cycle when wb_we=1 and wb_rd!=0 (write-first).
  - hazard masks any source that equals wb_rd while wb_we=1, so a read and write-back in the same cycle do not stall.
- Undefined:
  - regs_q is purely registered.
  - hazard is computed from busy_q only, which costs one extra stall cycle per dependency.

Decomposition:
- Shared package regunit_pkg holds:
  - XLEN and AW constants;
  - typedef xlen_t (logic [XLEN-1:0]);
  - typedef ridx_t (logic [AW-1:0]);
  - localparam ZERO_REG = 0.
- Scoreboard goes in a separate sub-module, regbank_scoreboard, covering the busy vector, pend_cnt, and the hazard logic.
- Storage stays in register_bank itself.

Test Plan:
- Reset: drive rst_n low asynchronously mid-cycle after writing x5=0xDEADBEEF. All of regs_q, busy_q and pend_cnt must read 0 immediately.
- Basic write: wb_we=1, wb_rd=7, wb_data=0x12345678 for one edge. regs_q[7] must be 0x12345678 on the next cycle, with all other registers unchanged.
- x0 protection:
  - wb_we=1, wb_rd=0, wb_data=0xFFFFFFFF must leave regs_q[0] = 0;
  - iss_valid=1, iss_rd=0 must leave busy_q = 0 and pend_cnt = 0.
- Hazard:
  - issue rd=3; next cycle rs1=3 must give hazard=1 and pend_cnt=1;
  - write back rd=3; with the macro undefined, hazard must be 1 in the write-back cycle and 0 the cycle after;
  - with REGBANK_WRITE_BYPASS_EN defined, hazard must be 0 in the write-back cycle and regs_q[3] must show wb_data.
- Simultaneous set and clear: with busy_q[9]=1, issue rd=9 and write back rd=9 in the same cycle. busy_q[9] must stay 1 and pend_cnt must be unchanged.
- Count: issue rd=1..31 on consecutive cycles; pend_cnt must reach 31. Then write back all 31; pend_cnt must return to 0 and hazard must be 0 for every rs1/rs2.
